// File: rtl/snn_pkg.sv
// Shared definitions for the tiny SNN: decoder FSM states and default sizing
// constants common to the neuron array and the rate decoder.
package snn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WINDOW = 256;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/spike_counter.sv
// One channel of the rate decoder: saturating spike counter with a sticky
// saturation bit, exposing the value that would be captured this cycle.
module spike_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             snap,
  output logic [CNT_W-1:0] snap_cnt,
  output logic             snap_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_reg;
  logic             sat_reg;
  logic             at_max;

  // snap_cnt/snap_sat already include this cycle's spike so the snapshot
  // taken on the last window cycle does not lose it.
  always_comb begin
    at_max   = (cnt_reg == CNT_MAX);
    snap_cnt = at_max ? cnt_reg : cnt_reg + CNT_W'(inc);
    snap_sat = sat_reg | (inc & at_max);
  end

  always_ff @(posedge clk) begin
    if (rst || clear || snap) begin
      cnt_reg <= '0;
      sat_reg <= 1'b0;
    end else begin
      cnt_reg <= snap_cnt;
      sat_reg <= snap_sat;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per channel over back-to-back windows and
// presents each window's counts on a valid/ready output with overrun flag.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       spike_in,
  output logic [NUM_CH*CNT_W-1:0] rate_data,
  output logic [NUM_CH-1:0]       sat,
  output logic                    rate_valid,
  input  logic                    rate_ready,
  output logic                    overrun,
  output logic                    win_active
);

  localparam int WW = $clog2(WINDOW);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  state_t                  state_reg, state_next;
  logic [WW-1:0]           win_cnt_reg;
  logic                    counting;
  logic                    last;
  logic [NUM_CH*CNT_W-1:0] snap_data;
  logic [NUM_CH-1:0]       snap_sat;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en)  state_next = COUNT;
      COUNT:   if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The entry edge (IDLE with en=1) is not a counting cycle.
  always_comb begin
    counting = (state_reg == COUNT) && en;
    last     = counting && (win_cnt_reg == WIN_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst || !counting || last) win_cnt_reg <= '0;
    else                          win_cnt_reg <= win_cnt_reg + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      spike_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (!counting),
        .inc      (counting & spike_in[gi]),
        .snap     (last),
        .snap_cnt (snap_data[gi*CNT_W +: CNT_W]),
        .snap_sat (snap_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_data  <= '0;
      sat        <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
      win_active <= 1'b0;
    end else begin
      win_active <= (state_next == COUNT);
      overrun    <= 1'b0;
      if (last) begin
        rate_data  <= snap_data;
        sat        <= snap_sat;
        rate_valid <= 1'b1;
        overrun    <= rate_valid && !rate_ready;
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench: two decoders (CNT_W=8 and CNT_W=3, WINDOW=16) share
// stimulus and are compared every cycle against a window-level reference model.
module tb_spike_rate_decoder;

  localparam int NCH = 4;
  localparam int WIN = 16;

  logic           clk = 1'b0;
  logic           rst, en, rate_ready;
  logic [NCH-1:0] spike_in;

  logic [NCH*8-1:0] data8;
  logic [NCH*3-1:0] data3;
  logic [NCH-1:0]   sat8, sat3;
  logic             valid8, valid3, ov8, ov3, act8, act3;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_CH(NCH), .WINDOW(WIN), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_data(data8), .sat(sat8), .rate_valid(valid8),
    .rate_ready(rate_ready), .overrun(ov8), .win_active(act8)
  );

  spike_rate_decoder #(.NUM_CH(NCH), .WINDOW(WIN), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_data(data3), .sat(sat3), .rate_valid(valid3),
    .rate_ready(rate_ready), .overrun(ov3), .win_active(act3)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a window is "running" with m_pos counted cycles and
  // unbounded spike totals; results are clipped only when the window ends.
  bit         m_active;
  int         m_pos;
  int         tot [NCH];
  bit         e_valid, e_ov;
  logic [31:0] e_data8;
  logic [11:0] e_data3;
  logic [3:0]  e_sat8, e_sat3;
  int         mode;   // 0 random, 1 decode pattern, 2 ch0 constant, 3 silent

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit snap, xfer;
    snap = 1'b0;
    e_ov = 1'b0;
    if (rst) begin
      m_active = 0; m_pos = 0; e_valid = 0;
      e_data8 = '0; e_data3 = '0; e_sat8 = '0; e_sat3 = '0;
      for (int i = 0; i < NCH; i++) tot[i] = 0;
      return;
    end
    xfer = e_valid && rate_ready;
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_pos = 0;
        for (int i = 0; i < NCH; i++) tot[i] = 0;
      end
    end else if (!en) begin
      m_active = 0;
    end else begin
      for (int i = 0; i < NCH; i++) tot[i] += int'(spike_in[i]);
      m_pos++;
      if (m_pos == WIN) begin
        snap = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          e_data8[i*8 +: 8] = (tot[i] > 255) ? 8'd255 : 8'(tot[i]);
          e_sat8[i]         = (tot[i] > 255);
          e_data3[i*3 +: 3] = (tot[i] > 7) ? 3'd7 : 3'(tot[i]);
          e_sat3[i]         = (tot[i] > 7);
          tot[i] = 0;
        end
        e_ov    = e_valid && !rate_ready;
        e_valid = 1'b1;
        m_pos   = 0;
      end
    end
    if (!snap && xfer) e_valid = 1'b0;
  endtask

  task automatic step();
    logic [NCH-1:0] sp;
    case (mode)
      1:       sp = {4'(m_active && m_pos == WIN-1), 1'b0, 1'b0, 1'b1}
                    | {2'b00, (m_pos % 2 == 1), 1'b0};
      2:       sp = 4'b0001;
      3:       sp = 4'b0000;
      default: sp = 4'($urandom_range(0, 15));
    endcase
    spike_in = sp;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid8", 32'(valid8), 32'(e_valid));
    chk("valid3", 32'(valid3), 32'(e_valid));
    chk("ovr8",   32'(ov8),    32'(e_ov));
    chk("ovr3",   32'(ov3),    32'(e_ov));
    chk("act8",   32'(act8),   32'(m_active));
    chk("act3",   32'(act3),   32'(m_active));
    chk("data8",  data8,       e_data8);
    chk("data3",  32'(data3),  32'(e_data3));
    chk("sat8",   32'(sat8),   32'(e_sat8));
    chk("sat3",   32'(sat3),   32'(e_sat3));
  endtask

  task automatic restart();
    en = 1'b0; step();
    en = 1'b1; step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rate_ready = 1'b1; spike_in = '0; mode = 0;
    m_active = 0; m_pos = 0; e_valid = 0; e_ov = 0;
    e_data8 = '0; e_data3 = '0; e_sat8 = '0; e_sat3 = '0;
    for (int i = 0; i < NCH; i++) tot[i] = 0;

    // Reset with random spikes and en high.
    repeat (3) step();
    chk("rst_out8", {data8[23:0], sat8, 1'b0, valid8, ov8, act8}, 32'h0);
    chk("rst_out3", {16'h0, data3, sat3}, 32'h0);
    rst = 1'b0; en = 1'b0; step();

    // Rate decode pattern; result lands exactly 16 edges after the entry edge.
    mode = 1; en = 1'b1; rate_ready = 1'b1;
    step();
    for (int n = 1; n <= WIN; n++) begin
      step();
      chk("latency", 32'(valid8), 32'(n == WIN));
    end
    chk("decode_data", data8, 32'h0100_0810);
    chk("decode_sat", 32'(sat8), 32'h0);
    step();
    chk("one_cycle_valid", 32'(valid8), 32'h0);
    chk("no_gap", 32'(act8), 32'h1);

    // Saturation at CNT_W=3, then a silent window clears sat.
    mode = 2; restart();
    repeat (WIN) step();
    chk("sat_data3", 32'(data3), 32'h007);
    chk("sat_flag3", 32'(sat3), 32'h1);
    mode = 3;
    repeat (WIN) step();
    chk("sat_cleared", 32'(sat3), 32'h0);

    // Back-pressure across two windows.
    mode = 2; rate_ready = 1'b0; restart();
    repeat (WIN) step();
    chk("bp_win1", data8, 32'h0000_0010);
    repeat (WIN - 1) step();
    chk("bp_no_early_ovr", 32'(ov8), 32'h0);
    step();
    chk("bp_overrun", 32'(ov8), 32'h1);
    en = 1'b0; step();
    chk("bp_ovr_pulse", 32'(ov8), 32'h0);
    chk("bp_held", 32'(valid8), 32'h1);
    rate_ready = 1'b1; step();
    chk("bp_drained", 32'(valid8), 32'h0);

    // Transfer and snapshot on the same edge.
    mode = 0; rate_ready = 1'b0; restart();
    repeat (2 * WIN - 1) step();
    rate_ready = 1'b1; step();
    chk("simul_valid", 32'(valid8), 32'h1);
    chk("simul_ovr", 32'(ov8), 32'h0);
    rate_ready = 1'b1; en = 1'b0; step();

    // Abort at window cycle 5, then a full window after re-enable.
    restart();
    repeat (5) step();
    en = 1'b0; step();
    chk("abort_inactive", 32'(act8), 32'h0);
    chk("abort_no_result", 32'(valid8), 32'h0);
    en = 1'b1; step();
    repeat (WIN) step();
    chk("reenable_result", 32'(valid8), 32'h1);

    // Reset while a result is pending.
    rate_ready = 1'b0;
    repeat (WIN + 4) step();
    rst = 1'b1; step();
    chk("rst_pending_valid", 32'(valid8), 32'h0);
    chk("rst_pending_ovr", 32'(ov8), 32'h0);
    rst = 1'b0; step();

    // Random en / ready traffic.
    for (int n = 0; n < 800; n++) begin
      en = ($urandom_range(0, 31) != 0);
      rate_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
